// File: rtl/audio_meter_pkg.sv
// audio_meter_pkg: shared defaults and mode encoding for the audio level meter.
//   DEF_SW / DEF_NUM_CH / DEF_HW / DEF_DECAY_CYCLES : default parameter values
//   MODE_INST / MODE_PEAK                            : 'mode' input encoding
package audio_meter_pkg;

  localparam int DEF_SW           = 16;
  localparam int DEF_NUM_CH       = 8;
  localparam int DEF_HW           = 4;
  localparam int DEF_DECAY_CYCLES = 48000;

  localparam logic MODE_INST = 1'b0;
  localparam logic MODE_PEAK = 1'b1;

endpackage

// File: rtl/audio_level_meter_abs_sat.sv
// abs_sat: combinational saturating absolute value.
//   din [SW-1:0]  signed two's complement input
//   mag [SW-2:0]  |din|; the most negative input saturates to all ones
module abs_sat #(
  parameter int SW = 16
) (
  input  logic [SW-1:0] din,
  output logic [SW-2:0] mag
);

  logic [SW-1:0] neg;

  assign neg = ~din + SW'(1);

  // Only -2^(SW-1) negates to a value with the sign bit still set.
  always_comb begin
    if (!din[SW-1])    mag = din[SW-2:0];
    else if (neg[SW-1]) mag = '1;
    else               mag = neg[SW-2:0];
  end

endmodule

// File: rtl/audio_level_meter.sv
// audio_level_meter: multi-channel bar-height generator.
// Three-stage pipeline: abs/sat -> shift/floor/clamp -> per-channel update,
// plus a free-running decay counter for peak-hold mode.
//   clk, rst (async, active low)
//   sample_valid, sample_in [SW], sample_ch [CHW] : time-multiplexed input
//   shift [4], floor_sub [HW], mode               : runtime controls
//   heights [NUM_CH*HW]                           : channel c at [c*HW +: HW]
//   height_valid, height_ch [CHW]                 : update pulse, 3 cycles after input
module audio_level_meter
  import audio_meter_pkg::*;
#(
  parameter int SW           = DEF_SW,
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int CHW          = $clog2(NUM_CH),
  parameter int HW           = DEF_HW,
  parameter int DECAY_CYCLES = DEF_DECAY_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_valid,
  input  logic [SW-1:0]        sample_in,
  input  logic [CHW-1:0]       sample_ch,
  input  logic [3:0]           shift,
  input  logic [HW-1:0]        floor_sub,
  input  logic                 mode,
  output logic [NUM_CH*HW-1:0] heights,
  output logic                 height_valid,
  output logic [CHW-1:0]       height_ch
);

  localparam int STAGES = 3;
  localparam int MW     = SW - 1;
  localparam int CW     = (DECAY_CYCLES > 1) ? $clog2(DECAY_CYCLES) : 1;
  localparam logic [MW-1:0] LVL_MAX = MW'((2 ** HW) - 1);

  logic [STAGES:1] vld_pipe;
  logic            s0_vld;
  logic [MW-1:0]   s0_mag;

  logic [MW-1:0]   s1_mag;
  logic [CHW-1:0]  s1_ch;

  logic [MW-1:0]   s_shr, s_sub;
  logic [HW-1:0]   s_lvl;
  logic [HW-1:0]   s2_lvl;
  logic [CHW-1:0]  s2_ch;

  logic [CW-1:0]   dcnt;
  logic            tick, dec_en;

  logic [NUM_CH-1:0][HW-1:0] h_q, h_nxt;

  // Stage 1: out-of-range channels never enter the pipeline.
  assign s0_vld = sample_valid && (int'(sample_ch) < NUM_CH);

  abs_sat #(.SW(SW)) u_abs (
    .din (sample_in),
    .mag (s0_mag)
  );

  // Stage 2: compare at full magnitude width before truncating to HW.
  always_comb begin
    s_shr = s1_mag >> shift;
    s_sub = (s_shr > MW'(floor_sub)) ? s_shr - MW'(floor_sub) : '0;
    s_lvl = (s_sub > LVL_MAX) ? '1 : s_sub[HW-1:0];
  end

  // Decay tick on counter wrap; only acts in peak-hold mode.
  assign tick   = (dcnt == CW'(DECAY_CYCLES - 1));
  assign dec_en = tick && (mode == MODE_PEAK);

  // Stage 3: decay first, then merge the incoming level so a same-cycle
  // update sees the decremented height. Back-to-back samples for one
  // channel need no forwarding since the update reads h_q directly.
  always_comb begin
    logic [HW-1:0] hd;
    h_nxt = h_q;
    for (int c = 0; c < NUM_CH; c++) begin
      hd = (dec_en && h_q[c] != '0) ? h_q[c] - HW'(1) : h_q[c];
      if (vld_pipe[2] && s2_ch == CHW'(c)) begin
        if (mode == MODE_PEAK) h_nxt[c] = (s2_lvl > hd) ? s2_lvl : hd;
        else                   h_nxt[c] = s2_lvl;
      end else begin
        h_nxt[c] = hd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe  <= '0;
      s1_mag    <= '0;
      s1_ch     <= '0;
      s2_lvl    <= '0;
      s2_ch     <= '0;
      h_q       <= '0;
      height_ch <= '0;
      dcnt      <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], s0_vld};
      dcnt     <= tick ? '0 : dcnt + CW'(1);
      if (s0_vld) begin
        s1_mag <= s0_mag;
        s1_ch  <= sample_ch;
      end
      if (vld_pipe[1]) begin
        s2_lvl <= s_lvl;
        s2_ch  <= s1_ch;
      end
      if (vld_pipe[2]) height_ch <= s2_ch;
      h_q <= h_nxt;
    end
  end

  assign heights      = h_q;
  assign height_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_audio_level_meter.sv
// tb_audio_level_meter: directed vectors with a scoreboard. Stimulus pushes
// {channel, height, expected edge}; a negedge monitor pops on height_valid.
module tb_audio_level_meter;
  localparam int SW = 16, NUM_CH = 6, CHW = 3, HW = 4, DEC = 4;

  logic clk = 1'b0, rst_n = 1'b0, sample_valid = 1'b0, mode = 1'b0;
  logic [SW-1:0]        sample_in = '0;
  logic [CHW-1:0]       sample_ch = '0;
  logic [3:0]           shift = '0;
  logic [HW-1:0]        floor_sub = '0;
  logic [NUM_CH*HW-1:0] heights;
  logic                 height_valid;
  logic [CHW-1:0]       height_ch;

  int tests = 0, fails = 0, edge_n = 0, m = 0;

  typedef struct {int ch; int h; int at;} exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  audio_level_meter #(.SW(SW), .NUM_CH(NUM_CH), .CHW(CHW), .HW(HW), .DECAY_CYCLES(DEC)) dut (
    .clk(clk), .rst(rst_n), .sample_valid(sample_valid), .sample_in(sample_in),
    .sample_ch(sample_ch), .shift(shift), .floor_sub(floor_sub), .mode(mode),
    .heights(heights), .height_valid(height_valid), .height_ch(height_ch)
  );

  always #5 clk = ~clk;

  // Edge index since reset release; ticks land on edges where edge_n % DEC == 0.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;

  function automatic int hgt(int c);
    return int'(heights[c*HW +: HW]);
  endfunction

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && height_valid) begin
      if (sbq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_valid: got height_valid ch=%0d expected none", height_ch);
      end else begin
        mon_e = sbq.pop_front();
        check("valid_ch", int'(height_ch), mon_e.ch);
        check("valid_height", hgt(mon_e.ch), mon_e.h);
        check("valid_latency", edge_n, mon_e.at);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  // exp_h < 0: no response expected.
  task automatic put(int ch, int smp, int exp_h);
    sample_valid = 1'b1;
    sample_ch    = CHW'(ch);
    sample_in    = SW'(smp);
    if (exp_h >= 0) sbq.push_back('{ch, exp_h, edge_n + 3});
  endtask

  task automatic one(int ch, int smp, int exp_h);
    put(ch, smp, exp_h);
    step();
    repeat (4) step();
  endtask

  task automatic wait_until(int n);
    int g = 0;
    while (edge_n < n && g < 100) begin step(); g++; end
    if (edge_n < n) begin tests++; fails++; $display("FAIL wait_edge: got %0d expected %0d", edge_n, n); end
  endtask

  task automatic sync_to(int ph);
    int g = 0;
    step();
    while ((edge_n % DEC) != ph && g < 8) begin step(); g++; end
  endtask

  initial begin
    #12;
    check("rst_heights", int'(heights), 0);
    check("rst_valid", int'(height_valid), 0);
    check("rst_ch", int'(height_ch), 0);
    @(negedge clk); rst_n = 1'b1;

    // instantaneous mode
    mode = 1'b0; shift = 4'd11; floor_sub = 4'd0;
    step();
    one(2, 'h7FFF, 15);
    one(2, -32768, 15);
    shift = 4'd8;  one(3, 'h1000, 15);
    shift = 4'd6;  one(4, -1000, 15);
    shift = 4'd2; floor_sub = 4'd3;  one(5, 40, 7);
    floor_sub = 4'd12;               one(5, 40, 0);
    shift = 4'd0; floor_sub = 4'd0;  one(0, -3, 3);
    check("heights_vec", int'(heights), 'h0FFF03);

    // out-of-range channels are dropped
    put(6, 'h7FFF, -1); step();
    put(7, 'h7FFF, -1); step();
    repeat (5) step();
    check("heights_unchanged", int'(heights), 'h0FFF03);

    // back-to-back, instantaneous
    put(1, 9, 9);   step();
    put(1, 3, 3);   step();
    put(1, 11, 11); step();
    repeat (4) step();
    one(1, 0, 0);

    // back-to-back, peak hold; updates placed between ticks
    mode = 1'b1;
    sync_to(2);
    put(1, 9, 9);   step();
    put(1, 3, 9);   step();
    put(1, 11, 11); step();
    repeat (4) step();

    // decay on ch0: update at m+3, ticks at m+6, m+10, m+14, m+18
    sync_to(2); m = edge_n;
    put(0, 10, 10); step();
    wait_until(m + 5);  check("peak_hold", hgt(0), 10);
    wait_until(m + 6);  check("decay_1", hgt(0), 9);
    wait_until(m + 10); check("decay_2", hgt(0), 8);
    wait_until(m + 11); put(0, 5, 7); step();
    wait_until(m + 13); check("pre_tick", hgt(0), 8);
    wait_until(m + 14); check("tick_and_update", hgt(0), 7);
    wait_until(m + 15); put(0, 12, 12); step();
    repeat (4) step();

    // async reset with samples in flight
    mode = 1'b0; shift = 4'd11;
    put(2, 'h7FFF, -1); step();
    put(3, 'h7FFF, -1); step();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_heights", int'(heights), 0);
    check("async_rst_valid", int'(height_valid), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) step();
    check("post_rst_heights", int'(heights), 0);
    one(4, 'h7FFF, 15);

    check("sb_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
